// File: rtl/calculator_seq_alu.sv
// rtl/calculator_seq_alu.sv - multi-cycle calculator ALU with start/busy/done handshake
module calculator_seq_alu #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       func,
   input  logic             chain,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             ovf,
   output logic             div0
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [2:0] F_ADD = 3'b000;
   localparam logic [2:0] F_SUB = 3'b001;
   localparam logic [2:0] F_MUL = 3'b010;
   localparam logic [2:0] F_DIV = 3'b011;
   localparam logic [2:0] F_MOD = 3'b100;
   localparam logic [2:0] F_SQR = 3'b101;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state;
   logic [2:0]         f_reg;
   // a_reg doubles as the dividend / quotient shift register during DIV and MOD
   logic [WIDTH-1:0]   a_reg;
   // b_reg is the divisor (held) or the multiplier (shifted right one bit per cycle)
   logic [WIDTH-1:0]   b_reg;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   rem;
   logic [CW-1:0]      cnt;

   logic [WIDTH-1:0]   a_sel;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   diff;
   logic [2*WIDTH-1:0] prod_nxt;
   logic [WIDTH:0]     trial;
   logic [WIDTH:0]     trial_diff;
   logic               sub_ok;
   logic [WIDTH-1:0]   rem_nxt;
   logic [WIDTH-1:0]   quot_nxt;
   logic               last;

   // Next-step values for the single-cycle ops and one iteration of multiply / divide
   always_comb begin
      a_sel      = chain ? result : op1;
      sum        = {1'b0, a_reg} + {1'b0, b_reg};
      diff       = a_reg - b_reg;
      prod_nxt   = prod + (b_reg[0] ? mcand : '0);
      trial      = {rem, a_reg[WIDTH-1]};
      trial_diff = trial - {1'b0, b_reg};
      sub_ok     = (trial >= {1'b0, b_reg});
      rem_nxt    = sub_ok ? trial_diff[WIDTH-1:0] : trial[WIDTH-1:0];
      quot_nxt   = {a_reg[WIDTH-2:0], sub_ok};
      last       = (cnt == CW'(WIDTH - 1));
   end

   // Control FSM and datapath; the DONE exit edge also accepts a new start so back-to-back ops take L+1 cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         f_reg  <= '0;
         a_reg  <= '0;
         b_reg  <= '0;
         mcand  <= '0;
         prod   <= '0;
         rem    <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         ovf    <= 1'b0;
         div0   <= 1'b0;
      end else begin
         case (state)
            CALC: begin
               case (f_reg)
                  F_ADD: begin
                     result <= sum[WIDTH-1:0];
                     ovf    <= sum[WIDTH];
                     div0   <= 1'b0;
                     state  <= DONE;
                     done   <= 1'b1;
                  end
                  F_SUB: begin
                     result <= diff;
                     ovf    <= (a_reg < b_reg);
                     div0   <= 1'b0;
                     state  <= DONE;
                     done   <= 1'b1;
                  end
                  F_MUL, F_SQR: begin
                     prod  <= prod_nxt;
                     mcand <= mcand << 1;
                     b_reg <= b_reg >> 1;
                     cnt   <= cnt + CW'(1);
                     if (last) begin
                        result <= prod_nxt[WIDTH-1:0];
                        ovf    <= |prod_nxt[2*WIDTH-1:WIDTH];
                        div0   <= 1'b0;
                        state  <= DONE;
                        done   <= 1'b1;
                     end
                  end
                  F_DIV, F_MOD: begin
                     if (b_reg == '0) begin
                        result <= (f_reg == F_DIV) ? {WIDTH{1'b1}} : a_reg;
                        ovf    <= 1'b0;
                        div0   <= 1'b1;
                        state  <= DONE;
                        done   <= 1'b1;
                     end else begin
                        rem   <= rem_nxt;
                        a_reg <= quot_nxt;
                        cnt   <= cnt + CW'(1);
                        if (last) begin
                           result <= (f_reg == F_DIV) ? quot_nxt : rem_nxt;
                           ovf    <= 1'b0;
                           div0   <= 1'b0;
                           state  <= DONE;
                           done   <= 1'b1;
                        end
                     end
                  end
                  default: begin
                     result <= '0;
                     ovf    <= 1'b0;
                     div0   <= 1'b0;
                     state  <= DONE;
                     done   <= 1'b1;
                  end
               endcase
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
               if (start) begin
                  f_reg <= func;
                  a_reg <= a_sel;
                  b_reg <= (func == F_SQR) ? a_sel : op2;
                  mcand <= {{WIDTH{1'b0}}, a_sel};
                  prod  <= '0;
                  rem   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_calculator_seq_alu.sv
// tb/tb_calculator_seq_alu.sv - directed scoreboard bench for calculator_seq_alu
module tb_calculator_seq_alu;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [2:0]   func;
   logic         chain;
   logic [W-1:0] op1;
   logic [W-1:0] op2;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         ovf;
   logic         div0;

   calculator_seq_alu #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .func   (func),
      .chain  (chain),
      .op1    (op1),
      .op2    (op2),
      .busy   (busy),
      .done   (done),
      .result (result),
      .ovf    (ovf),
      .div0   (div0)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        tag;
      logic [W-1:0] res;
      logic         ovf;
      logic         div0;
      int           lat;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] model_res;
   int           n_cmp = 0;
   int           n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input string tag, input logic [2:0] f,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int   t;
      e.tag  = tag;
      e.res  = '0;
      e.ovf  = 1'b0;
      e.div0 = 1'b0;
      e.lat  = 1;
      case (f)
         3'd0: begin
            t = int'(a) + int'(b);
            e.res = W'(t);
            e.ovf = (t > (1 << W) - 1);
         end
         3'd1: begin
            t = int'(a) - int'(b);
            e.res = W'(t);
            e.ovf = (a < b);
         end
         3'd2, 3'd5: begin
            t = int'(a) * ((f == 3'd5) ? int'(a) : int'(b));
            e.res = W'(t);
            e.ovf = ((t >> W) != 0);
            e.lat = W;
         end
         3'd3, 3'd4: begin
            if (b == 0) begin
               e.div0 = 1'b1;
               e.res  = (f == 3'd3) ? {W{1'b1}} : a;
            end else begin
               e.lat = W;
               e.res = (f == 3'd3) ? W'(int'(a) / int'(b)) : W'(int'(a) % int'(b));
            end
         end
         default: e.res = '0;
      endcase
      return e;
   endfunction

   task automatic run_op(input string tag, input logic [2:0] f, input logic [W-1:0] a_in,
                         input logic [W-1:0] b_in, input logic ch, input int disturb);
      exp_t         e;
      int           n;
      int           extra;
      logic [W-1:0] a_eff;
      @(negedge clk);
      func  = f;
      op1   = a_in;
      op2   = b_in;
      chain = ch;
      start = 1'b1;
      a_eff = ch ? model_res : a_in;
      sb.push_back(model(tag, f, a_eff, b_in));
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      n = 1;
      chk({tag, "_busy"}, busy, 1);
      while (!done && n < 40) begin
         if (disturb != 0 && n == 2) begin
            start = 1'b1;
            op1   = ~op1;
            op2   = op2 + 8'd3;
            func  = 3'b000;
            chain = ~chain;
         end
         if (disturb != 0 && n == 3) start = 1'b0;
         @(negedge clk);
         n++;
      end
      e = sb.pop_front();
      chk({tag, "_done"}, done, 1);
      chk({tag, "_lat"}, n, e.lat + 1);
      chk({tag, "_res"}, result, e.res);
      chk({tag, "_ovf"}, ovf, e.ovf);
      chk({tag, "_div0"}, div0, e.div0);
      model_res = e.res;
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_idle"}, busy, 0);
      if (disturb != 0) begin
         extra = 0;
         repeat (W + 3) begin
            @(negedge clk);
            if (done) extra++;
         end
         chk({tag, "_no_extra"}, extra, 0);
         chk({tag, "_res_held"}, result, e.res);
      end
   endtask

   initial begin
      int d;
      rst   = 1'b1;
      start = 1'b0;
      func  = '0;
      chain = 1'b0;
      op1   = '0;
      op2   = '0;
      model_res = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_result", result, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_div0", div0, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);

      run_op("add_carry",  3'd0, 8'hF0, 8'h20, 1'b0, 0);
      run_op("sub_borrow", 3'd1, 8'h05, 8'h07, 1'b0, 0);
      run_op("mul_ff",     3'd2, 8'h0F, 8'h11, 1'b0, 0);
      run_op("mul_ovf",    3'd2, 8'h10, 8'h10, 1'b0, 0);
      run_op("square",     3'd5, 8'h0C, 8'h55, 1'b0, 0);
      run_op("div",        3'd3, 8'd200, 8'd7, 1'b0, 0);
      run_op("mod",        3'd4, 8'd200, 8'd7, 1'b0, 0);
      run_op("div_zero",   3'd3, 8'h37, 8'h00, 1'b0, 0);
      run_op("mod_zero",   3'd4, 8'h37, 8'h00, 1'b0, 0);
      run_op("after_div0", 3'd0, 8'h01, 8'h02, 1'b0, 0);
      run_op("chain_add",  3'd0, 8'h05, 8'h03, 1'b0, 0);
      run_op("chain_sub",  3'd1, 8'h99, 8'h02, 1'b1, 0);
      run_op("clr",        3'd6, 8'hAB, 8'hCD, 1'b0, 0);
      run_op("pre_rsvd",   3'd0, 8'h10, 8'h20, 1'b0, 0);
      run_op("reserved",   3'd7, 8'h12, 8'h34, 1'b0, 0);
      run_op("mul_restart",   3'd2, 8'h0F, 8'h11, 1'b0, 1);
      run_op("div_op_change", 3'd3, 8'd200, 8'd7, 1'b0, 1);

      // start held high with ADD: a completion every second cycle
      @(negedge clk);
      func  = 3'd0;
      op1   = 8'h01;
      op2   = 8'h01;
      chain = 1'b0;
      start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk($sformatf("hold_done_%0d", k), done, (k % 2 == 0) ? 1 : 0);
         if (k % 2 == 0) chk($sformatf("hold_res_%0d", k), result, 8'h02);
         chk($sformatf("hold_busy_%0d", k), busy, 1);
      end
      start = 1'b0;
      model_res = 8'h02;
      @(negedge clk);
      chk("hold_stop_done", done, 0);
      chk("hold_stop_busy", busy, 0);

      // reset in the third cycle of a MUL
      @(negedge clk);
      func  = 3'd2;
      op1   = 8'h0F;
      op2   = 8'h11;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_result", result, 0);
      chk("abort_ovf", ovf, 0);
      chk("abort_div0", div0, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      model_res = '0;
      d = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) d++;
      end
      chk("abort_no_done", d, 0);
      run_op("fresh_add", 3'd0, 8'h01, 8'h01, 1'b0, 0);

      // chaining straight after reset uses a = 0
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_res = '0;
      run_op("chain_after_rst", 3'd0, 8'h44, 8'h03, 1'b1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
